// File: rtl/axi_wb_line_buffer_pkg.sv
// Shared AXI constants and write-FSM state type for the write-back line buffer.
package axi_wb_line_buffer_pkg;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_STRB_ALL   = 4'b1111;
  localparam int unsigned WORD_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } wb_state_t;

endpackage

// File: rtl/axi_wb_line_buffer_wb_entry_array.sv
// Line storage for the write-back buffer: valid/tag/data per slot, one write
// port, one clear port, head read port and youngest-match lookup.
module wb_entry_array #(
  parameter int unsigned LINE_SIZE = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [$clog2(DEPTH)-1:0]                wr_idx,
  input  logic [ADDR_W-$clog2(LINE_SIZE)-1:0]     wr_tag,
  input  logic [LINE_SIZE*8-1:0]                  wr_data,
  input  logic                                    clr_en,
  input  logic [$clog2(DEPTH)-1:0]                head,
  output logic [ADDR_W-1:0]                       rd_addr,
  output logic [LINE_SIZE*8-1:0]                  rd_data,
  input  logic [ADDR_W-$clog2(LINE_SIZE)-1:0]     lk_tag,
  output logic                                    lk_hit,
  output logic [LINE_SIZE*8-1:0]                  lk_data
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W;
  localparam int unsigned DATA_W = LINE_SIZE * 8;

  logic [DEPTH-1:0]  valid;
  logic [TAG_W-1:0]  tag  [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [PTR_W-1:0]  idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[head]   <= 1'b0;
      if (wr_en)  valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]  <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_addr = {tag[head], {OFF_W{1'b0}}};
  assign rd_data = data[head];

  // Valid slots are contiguous from head, so scanning oldest to youngest and
  // letting later matches override yields the youngest match.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && (tag[idx] == lk_tag)) begin
        lk_hit  = 1'b1;
        lk_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/axi_wb_line_buffer.sv
// Write-back line buffer: queues dirty lines and drains them oldest-first as
// single-outstanding AXI INCR bursts; lookup port exposes pending line data.
module axi_wb_line_buffer
  import axi_wb_line_buffer_pkg::*;
#(
  parameter int unsigned LINE_SIZE = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [ADDR_W-1:0]      push_addr,
  input  logic [LINE_SIZE*8-1:0] push_data,
  output logic                   full,
  output logic                   empty,
  input  logic [ADDR_W-1:0]      lk_addr,
  output logic                   lk_hit,
  output logic [LINE_SIZE*8-1:0] lk_data,
  output logic [ADDR_W-1:0]      axi_awaddr,
  output logic [7:0]             axi_awlen,
  output logic [2:0]             axi_awsize,
  output logic [1:0]             axi_awburst,
  output logic                   axi_awvalid,
  input  logic                   axi_awready,
  output logic [31:0]            axi_wdata,
  output logic [3:0]             axi_wstrb,
  output logic                   axi_wlast,
  output logic                   axi_wvalid,
  input  logic                   axi_wready,
  input  logic                   axi_bvalid,
  output logic                   axi_bready
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OFF_W  = $clog2(LINE_SIZE);
  localparam int unsigned BEATS  = LINE_SIZE / 4;
  localparam int unsigned BEAT_W = $clog2(BEATS);

  wb_state_t                state;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W:0]           count;
  logic [BEAT_W-1:0]        beat;
  logic [BEAT_W-1:0]        beat_nxt;
  logic                     push_ok;
  logic                     pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [LINE_SIZE*8-1:0]   head_data;
  logic                     unused_addr_bits;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0) && (state == ST_IDLE);
  assign push_ok = push && !full;
  assign pop     = (state == ST_B) && axi_bvalid;
  assign beat_nxt = beat + BEAT_W'(1);

  assign axi_awlen   = 8'(BEATS - 1);
  assign axi_awsize  = AXI_SIZE_4B;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wstrb   = AXI_STRB_ALL;

  assign unused_addr_bits = ^{push_addr[OFF_W-1:0], lk_addr[OFF_W-1:0]};

  wb_entry_array #(
    .LINE_SIZE(LINE_SIZE),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_entries (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (push_ok),
    .wr_idx (tail),
    .wr_tag (push_addr[ADDR_W-1:OFF_W]),
    .wr_data(push_data),
    .clr_en (pop),
    .head   (head),
    .rd_addr(head_addr),
    .rd_data(head_data),
    .lk_tag (lk_addr[ADDR_W-1:OFF_W]),
    .lk_hit (lk_hit),
    .lk_data(lk_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      beat        <= '0;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wvalid  <= 1'b0;
      axi_wlast   <= 1'b0;
      axi_bready  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (count != '0) begin
            axi_awaddr  <= head_addr;
            axi_awvalid <= 1'b1;
            state       <= ST_AW;
          end
        end
        ST_AW: begin
          if (axi_awready) begin
            axi_awvalid <= 1'b0;
            beat        <= '0;
            axi_wvalid  <= 1'b1;
            axi_wdata   <= head_data[WORD_W-1:0];
            axi_wlast   <= 1'b0;
            state       <= ST_W;
          end
        end
        ST_W: begin
          if (axi_wready) begin
            if (beat == BEAT_W'(BEATS - 1)) begin
              axi_wvalid <= 1'b0;
              axi_wlast  <= 1'b0;
              axi_bready <= 1'b1;
              state      <= ST_B;
            end else begin
              beat      <= beat_nxt;
              axi_wdata <= head_data[WORD_W*beat_nxt +: WORD_W];
              axi_wlast <= (beat_nxt == BEAT_W'(BEATS - 1));
            end
          end
        end
        ST_B: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wb_line_buffer.sv
// Scoreboard bench for axi_wb_line_buffer: stimulus queues expected AW/W beats,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_axi_wb_line_buffer;

  localparam int unsigned LS = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            push;
  logic [AW-1:0]   push_addr;
  logic [LS*8-1:0] push_data;
  logic            full, empty;
  logic [AW-1:0]   lk_addr;
  logic            lk_hit;
  logic [LS*8-1:0] lk_data;
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic            axi_awvalid, axi_awready;
  logic [31:0]     axi_wdata;
  logic [3:0]      axi_wstrb;
  logic            axi_wlast, axi_wvalid, axi_wready;
  logic            axi_bvalid, axi_bready;

  always #5 clk = ~clk;

  axi_wb_line_buffer #(.LINE_SIZE(LS), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q_aw[$];
  logic [32:0] q_w[$];
  int          b_exp = 0;
  int          b_seen = 0;
  bit          b_auto = 1'b1;
  int          b_delay = 0;
  int          b_cnt = 0;
  bit          wr_pat = 1'b0;
  bit          pat[3] = '{1'b1, 1'b0, 1'b0};
  int          pidx = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LS*8-1:0] mk(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic push_line(input logic [31:0] addr, input logic [LS*8-1:0] data, input bit accept);
    push = 1'b1;
    push_addr = addr;
    push_data = data;
    if (accept) begin
      q_aw.push_back(addr & ~32'hF);
      for (int i = 0; i < 4; i++) begin
        logic l;
        l = (i == 3);
        q_w.push_back({l, data[32*i +: 32]});
      end
      b_exp++;
    end
    tick();
    push = 1'b0;
  endtask

  task automatic wait_bready(input string name);
    int t = 0;
    while (!axi_bready && t < 100) begin
      tick();
      t++;
    end
    check(name, axi_bready, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (!(empty && q_aw.size() == 0 && q_w.size() == 0) && t < 300) begin
      tick();
      t++;
    end
    check({name, "_empty"}, empty, 1'b1);
    check({name, "_bcount"}, b_seen, b_exp);
    check({name, "_aw_left"}, q_aw.size(), 0);
    check({name, "_w_left"}, q_w.size(), 0);
  endtask

  // Monitor: sampled on the falling edge, between input updates and the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (axi_awvalid && axi_awready) begin
          if (q_aw.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL aw_unexpected: got %0h expected none", axi_awaddr);
          end else begin
            check("awaddr", axi_awaddr, q_aw.pop_front());
            check("awlen", axi_awlen, 8'd3);
          end
        end
        if (axi_wvalid) begin
          if (q_w.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w_unexpected: got %0h expected none", axi_wdata);
          end else begin
            check("wlast_wdata", {axi_wlast, axi_wdata}, q_w[0]);
            check("wstrb", axi_wstrb, 4'hF);
            if (axi_wready) void'(q_w.pop_front());
          end
        end
        if (axi_bready) check("no_aw_in_b", axi_awvalid, 1'b0);
        if (axi_bvalid && axi_bready) b_seen++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst !== 1'b1) begin
        axi_bvalid = 1'b0;
        b_cnt = 0;
      end else if (b_auto) begin
        if (axi_bvalid) axi_bvalid = 1'b0;
        else if (axi_bready) begin
          if (b_cnt >= b_delay) begin
            axi_bvalid = 1'b1;
            b_cnt = 0;
          end else b_cnt++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wr_pat) begin
        axi_wready = pat[pidx];
        pidx = (pidx + 1) % 3;
      end else begin
        axi_wready = 1'b1;
        pidx = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; push = 1'b0; push_addr = '0; push_data = '0; lk_addr = '0;
    axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0;
    tick(); tick();
    check("rst_awvalid", axi_awvalid, 1'b0);
    check("rst_wvalid", axi_wvalid, 1'b0);
    check("rst_wlast", axi_wlast, 1'b0);
    check("rst_bready", axi_bready, 1'b0);
    check("rst_awaddr", axi_awaddr, 32'h0);
    check("rst_wdata", axi_wdata, 32'h0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_lk_hit", lk_hit, 1'b0);
    rst = 1'b1;
    tick();

    // 1: single line, all readies high
    push_line(32'h1000_0004, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
    check("t1_empty_after_push", empty, 1'b0);
    tick();
    check("t1_awvalid", axi_awvalid, 1'b1);
    check("t1_awaddr", axi_awaddr, 32'h1000_0000);
    check("t1_awlen", axi_awlen, 8'd3);
    wait_drain("t1");

    // 2: fill with awready low, 5th push dropped, drain in order
    axi_awready = 1'b0;
    for (int i = 0; i < 4; i++) push_line(32'h3000 + 32'(i) * 32'h10, mk(32'h300 + 32'(i) * 32'h10), 1'b1);
    check("t2_full", full, 1'b1);
    push_line(32'h3040, mk(32'h340), 1'b0);
    check("t2_full_after_drop", full, 1'b1);
    axi_awready = 1'b1;
    wait_drain("t2");

    // 3: wready 1,0,0 pattern and delayed B
    wr_pat = 1'b1; b_delay = 5;
    push_line(32'h4000, mk(32'h400), 1'b1);
    push_line(32'h4010, mk(32'h410), 1'b1);
    wait_drain("t3");
    wr_pat = 1'b0; b_delay = 0;

    // 4: duplicate lines, youngest wins on lookup
    axi_awready = 1'b0;
    push_line(32'h2000, mk(32'hA00), 1'b1);
    push_line(32'h2000, mk(32'hB00), 1'b1);
    lk_addr = 32'h2008; #1;
    check("t4_lk_hit", lk_hit, 1'b1);
    check("t4_lk_data", lk_data, mk(32'hB00));
    lk_addr = 32'h2010; #1;
    check("t4_lk_miss", lk_hit, 1'b0);
    check("t4_lk_miss_data", lk_data, 128'h0);
    lk_addr = 32'h2008;
    axi_awready = 1'b1;
    wait_drain("t4");
    #1;
    check("t4_lk_after", lk_hit, 1'b0);

    // 5: push coinciding with B completion
    axi_awready = 1'b0; b_auto = 1'b0;
    for (int i = 0; i < 4; i++) push_line(32'h5000 + 32'(i) * 32'h10, mk(32'h500 + 32'(i) * 32'h10), 1'b1);
    check("t5_full", full, 1'b1);
    axi_awready = 1'b1;
    wait_bready("t5_bready_a");
    axi_bvalid = 1'b1;
    push_line(32'h5040, mk(32'h540), 1'b0);
    axi_bvalid = 1'b0;
    check("t5a_not_full", full, 1'b0);
    push_line(32'h5050, mk(32'h550), 1'b1);
    check("t5a_count3_refill", full, 1'b1);
    for (int i = 0; i < 2; i++) begin
      wait_bready("t5_bready_pop");
      axi_bvalid = 1'b1;
      tick();
      axi_bvalid = 1'b0;
    end
    wait_bready("t5_bready_b");
    axi_bvalid = 1'b1;
    push_line(32'h5060, mk(32'h560), 1'b1);
    axi_bvalid = 1'b0;
    check("t5b_not_full", full, 1'b0);
    push_line(32'h5070, mk(32'h570), 1'b1);
    check("t5b_count3", full, 1'b0);
    push_line(32'h5080, mk(32'h580), 1'b1);
    check("t5b_count4", full, 1'b1);
    b_auto = 1'b1;
    wait_drain("t5");

    // 6: reset during the second W beat
    push_line(32'h6000, mk(32'h600), 1'b1);
    begin
      int t = 0;
      while (!axi_wvalid && t < 50) begin tick(); t++; end
    end
    check("t6_wvalid_seen", axi_wvalid, 1'b1);
    tick();
    check("t6_beat2", axi_wdata, 32'h601);
    rst = 1'b0;
    tick();
    check("t6_wvalid_rst", axi_wvalid, 1'b0);
    check("t6_empty_rst", empty, 1'b1);
    lk_addr = 32'h6000; #1;
    check("t6_lk_hit_rst", lk_hit, 1'b0);
    q_aw.delete(); q_w.delete(); b_exp = b_seen;
    rst = 1'b1;
    tick();
    push_line(32'h7000, mk(32'h700), 1'b1);
    wait_drain("t6_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
